// File: rtl/nx_stream_decoder.sv
// Steers an arbitrated message stream to local or one of four mesh links (row first, then column),
// with a 1-entry holding stage and a 2-entry FIFO per destination. Optional NX_DECODER_STATS_EN adds push counters.
module nx_stream_decoder #(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_W-1:0]       node_row_i,
  input  logic [ADDR_W-1:0]       node_col_i,
  input  logic [STREAM_WIDTH-1:0] in_data_i,
  input  logic [1:0]              in_dir_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [STREAM_WIDTH-1:0] north_data_o,
  output logic                    north_valid_o,
  input  logic                    north_ready_i,
  output logic [STREAM_WIDTH-1:0] east_data_o,
  output logic                    east_valid_o,
  input  logic                    east_ready_i,
  output logic [STREAM_WIDTH-1:0] south_data_o,
  output logic                    south_valid_o,
  input  logic                    south_ready_i,
  output logic [STREAM_WIDTH-1:0] west_data_o,
  output logic                    west_valid_o,
  input  logic                    west_ready_i,
  output logic [STREAM_WIDTH-1:0] local_data_o,
  output logic                    local_valid_o,
  input  logic                    local_ready_i,
  output logic                    bounce_o,
  input  logic [2:0]              stat_sel_i,
  output logic [15:0]             stat_count_o
);

  // Destination index doubles as the arrival-direction code for N/E/S/W.
  localparam logic [2:0] DEST_N = 3'd0;
  localparam logic [2:0] DEST_E = 3'd1;
  localparam logic [2:0] DEST_S = 3'd2;
  localparam logic [2:0] DEST_W = 3'd3;
  localparam logic [2:0] DEST_L = 3'd4;
  localparam int         NDEST  = 5;

  // Handshake: a transfer happens on a rising clk_i edge where valid and ready are both high;
  // valid never depends on ready, and data is held stable while valid is high and ready is low.

  logic [STREAM_WIDTH-1:0] hold_data;
  logic [1:0]              hold_dir;
  logic                    hold_valid;

  logic [ADDR_W-1:0]       tgt_row;
  logic [ADDR_W-1:0]       tgt_col;
  logic [2:0]              dest;
  logic [NDEST-1:0]        dest_oh;
  logic [NDEST-1:0]        fifo_full;
  logic [NDEST-1:0]        push_oh;
  logic                    push;
  logic                    accept;
  logic                    bounce_q;

  logic [1:0]              fifo_cnt [NDEST];
  logic                    fifo_wp  [NDEST];
  logic                    fifo_rp  [NDEST];
  logic [STREAM_WIDTH-1:0] fifo_mem [NDEST][2];
  logic [NDEST-1:0]        out_valid;
  logic [NDEST-1:0]        out_ready;
  logic [NDEST-1:0]        pop;
  logic [STREAM_WIDTH-1:0] head     [NDEST];

  assign tgt_row = hold_data[STREAM_WIDTH-1 -: ADDR_W];
  assign tgt_col = hold_data[STREAM_WIDTH-1-ADDR_W -: ADDR_W];

  always_comb begin
    dest = DEST_L;
    if (tgt_row < node_row_i) begin
      dest = DEST_N;
    end else if (tgt_row > node_row_i) begin
      dest = DEST_S;
    end else if (tgt_col < node_col_i) begin
      dest = DEST_W;
    end else if (tgt_col > node_col_i) begin
      dest = DEST_E;
    end
  end

  always_comb begin
    dest_oh   = '0;
    fifo_full = '0;
    for (int d = 0; d < NDEST; d++) begin
      dest_oh[d]   = (dest == 3'(d));
      fifo_full[d] = (fifo_cnt[d] == 2'd2);
    end
  end

  // Space is judged on the registered count only, so a same-cycle pop never lets a push through.
  assign push       = hold_valid && |(dest_oh & ~fifo_full);
  assign push_oh    = dest_oh & {NDEST{push}};
  assign in_ready_o = !hold_valid || push;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_dir   <= 2'd0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data_i;
      hold_dir   <= in_dir_i;
    end else if (push) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= push && (dest == {1'b0, hold_dir});
    end
  end

  assign bounce_o = bounce_q;

  assign out_ready = {local_ready_i, west_ready_i, south_ready_i, east_ready_i, north_ready_i};
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NDEST; d++) begin
        fifo_cnt[d] <= 2'd0;
        fifo_wp[d]  <= 1'b0;
        fifo_rp[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < NDEST; d++) begin
        if (push_oh[d]) begin
          fifo_wp[d] <= ~fifo_wp[d];
        end
        if (pop[d]) begin
          fifo_rp[d] <= ~fifo_rp[d];
        end
        case ({push_oh[d], pop[d]})
          2'b10:   fifo_cnt[d] <= fifo_cnt[d] + 2'd1;
          2'b01:   fifo_cnt[d] <= fifo_cnt[d] - 2'd1;
          default: fifo_cnt[d] <= fifo_cnt[d];
        endcase
      end
    end
  end

  // Storage needs no reset: an entry is only visible once its count says so.
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < NDEST; d++) begin
      if (push_oh[d]) begin
        fifo_mem[d][fifo_wp[d]] <= hold_data;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int d = 0; d < NDEST; d++) begin
      out_valid[d] = (fifo_cnt[d] != 2'd0);
      head[d]      = fifo_mem[d][fifo_rp[d]];
    end
  end

  assign north_valid_o = out_valid[DEST_N];
  assign east_valid_o  = out_valid[DEST_E];
  assign south_valid_o = out_valid[DEST_S];
  assign west_valid_o  = out_valid[DEST_W];
  assign local_valid_o = out_valid[DEST_L];
  assign north_data_o  = head[DEST_N];
  assign east_data_o   = head[DEST_E];
  assign south_data_o  = head[DEST_S];
  assign west_data_o   = head[DEST_W];
  assign local_data_o  = head[DEST_L];

`ifdef NX_DECODER_STATS_EN
  logic [15:0] stat_cnt [NDEST];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < NDEST; d++) begin
        stat_cnt[d] <= 16'd0;
      end
    end else begin
      for (int d = 0; d < NDEST; d++) begin
        if (push_oh[d] && (stat_cnt[d] != 16'hFFFF)) begin
          stat_cnt[d] <= stat_cnt[d] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_count_o = 16'd0;
    case (stat_sel_i)
      3'd0:    stat_count_o = stat_cnt[0];
      3'd1:    stat_count_o = stat_cnt[1];
      3'd2:    stat_count_o = stat_cnt[2];
      3'd3:    stat_count_o = stat_cnt[3];
      3'd4:    stat_count_o = stat_cnt[4];
      default: stat_count_o = 16'd0;
    endcase
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel_i;
  assign stat_count_o    = 16'd0;
`endif

endmodule
